// File: rtl/izh_pkg.sv
// Shared types and constants for the Izhikevich parameter sequencer.
// IZH_PARAM_CHECKSUM_EN adds an 8-bit XOR trailer to every parameter frame.
package izh_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        COMMIT = 3'd2,
        RUN    = 3'd3,
        ABORT  = 3'd4,
        CKFAIL = 3'd5
    } state_t;

    localparam logic [7:0] DEF_A = 8'h02;
    localparam logic [7:0] DEF_B = 8'h33;
    localparam logic [7:0] DEF_C = 8'hBF;
    localparam logic [7:0] DEF_D = 8'h08;

    // The trailer, when present, is one extra parameter-width word.
    function automatic int frame_bits(input int num_params, input int param_w);
`ifdef IZH_PARAM_CHECKSUM_EN
        return (num_params + 1) * param_w;
`else
        return num_params * param_w;
`endif
    endfunction

endpackage

// File: rtl/izh_step_divider.sv
// Cycle divider producing a one-cycle step strobe every STEP_DIV counting cycles.
// clear zeroes the phase; enable=0 freezes it and masks the strobe.
module izh_step_divider #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic pulse
);

    localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic             pulse_q;
    logic             wrap;

    assign wrap = (div_q == DIV_W'(STEP_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            pulse_q <= 1'b0;
        end else if (enable) begin
            if (clear) begin
                div_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= wrap;
                div_q   <= wrap ? '0 : div_q + 1'b1;
            end
        end
    end

    assign pulse = pulse_q & enable;

endmodule

// File: rtl/izh_param_sequencer.sv
// Serial a/b/c/d parameter loader with atomic commit and step scheduling.
// IZH_PARAM_CHECKSUM_EN: frames carry an XOR trailer; a bad trailer routes to CKFAIL.
module izh_param_sequencer
    import izh_pkg::*;
#(
    parameter int PARAM_W    = 8,
    parameter int NUM_PARAMS = 4,
    parameter int STEP_DIV   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               load_mode,
    input  logic               serial_data,
    input  logic               input_enable,
    output logic [PARAM_W-1:0] param_a,
    output logic [PARAM_W-1:0] param_b,
    output logic [PARAM_W-1:0] param_c,
    output logic [PARAM_W-1:0] param_d,
    output logic               params_ready,
    output logic               step_pulse,
    output logic [2:0]         debug_state
);

    localparam int FRAME_BITS = frame_bits(NUM_PARAMS, PARAM_W);
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int A_LSB      = FRAME_BITS - PARAM_W;
    localparam int B_LSB      = A_LSB - PARAM_W;
    localparam int C_LSB      = B_LSB - PARAM_W;
    localparam int D_LSB      = C_LSB - PARAM_W;

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_next;
    logic [CNT_W-1:0]        count_q;
    logic [PARAM_W-1:0]      a_q, b_q, c_q, d_q;
    logic                    valid_q, ready_q, load_mode_q;
    logic                    frame_start, frame_done, check_ok, div_clear;

    assign frame_start = load_mode && !load_mode_q && (state_q == IDLE || state_q == RUN);
    assign shift_next  = {shift_q[FRAME_BITS-2:0], serial_data};
    assign frame_done  = (count_q == CNT_W'(FRAME_BITS - 1));

`ifdef IZH_PARAM_CHECKSUM_EN
    assign check_ok = ((shift_next[A_LSB +: PARAM_W] ^ shift_next[B_LSB +: PARAM_W] ^
                        shift_next[C_LSB +: PARAM_W] ^ shift_next[D_LSB +: PARAM_W])
                       == shift_next[PARAM_W-1:0]);
`else
    assign check_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (frame_start)                   state_d = SHIFT;
                else if (valid_q && input_enable)  state_d = RUN;
            end
            SHIFT: begin
                if (!load_mode)                    state_d = ABORT;
                else if (frame_done)               state_d = check_ok ? COMMIT : CKFAIL;
            end
            RUN: begin
                if (frame_start)                   state_d = SHIFT;
                else if (!input_enable)            state_d = IDLE;
            end
            COMMIT, ABORT, CKFAIL:                 state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            count_q     <= '0;
            a_q         <= PARAM_W'(DEF_A);
            b_q         <= PARAM_W'(DEF_B);
            c_q         <= PARAM_W'(DEF_C);
            d_q         <= PARAM_W'(DEF_D);
            valid_q     <= 1'b0;
            ready_q     <= 1'b0;
            load_mode_q <= 1'b0;
        end else if (enable) begin
            state_q     <= state_d;
            load_mode_q <= load_mode;
            // The edge cycle itself carries the first frame bit.
            if (frame_start) begin
                shift_q <= FRAME_BITS'(serial_data);
                count_q <= CNT_W'(1);
            end else if (state_q == SHIFT && load_mode) begin
                shift_q <= shift_next;
                count_q <= count_q + 1'b1;
            end else if (state_q == COMMIT || state_q == ABORT || state_q == CKFAIL) begin
                shift_q <= '0;
                count_q <= '0;
            end
            if (state_q == COMMIT) begin
                a_q     <= shift_q[A_LSB +: PARAM_W];
                b_q     <= shift_q[B_LSB +: PARAM_W];
                c_q     <= shift_q[C_LSB +: PARAM_W];
                d_q     <= shift_q[D_LSB +: PARAM_W];
                valid_q <= 1'b1;
            end
            ready_q <= (state_d == SHIFT || state_d == COMMIT) ? 1'b0
                                                               : (valid_q || state_q == COMMIT);
        end
    end

    // Leaving RUN, or a pending frame start, zeroes the phase so the next RUN entry starts fresh.
    assign div_clear = !(state_q == RUN && state_d == RUN);

    izh_step_divider #(
        .STEP_DIV(STEP_DIV)
    ) u_step_divider (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .clear (div_clear),
        .pulse (step_pulse)
    );

    assign param_a      = a_q;
    assign param_b      = b_q;
    assign param_c      = c_q;
    assign param_d      = d_q;
    assign params_ready = ready_q;
    assign debug_state  = state_q;

endmodule

// File: tb/tb_izh_param_sequencer.sv
// Directed bench for izh_param_sequencer: reset, frame load, abort, overlong window,
// enable freeze, reset mid-frame and (with IZH_PARAM_CHECKSUM_EN) trailer checking.
module tb_izh_param_sequencer;

`ifdef IZH_PARAM_CHECKSUM_EN
    localparam int FB = 40;
`else
    localparam int FB = 32;
`endif

    logic       clk;
    logic       reset, enable, load_mode, serial_data, input_enable;
    logic [7:0] param_a, param_b, param_c, param_d;
    logic       params_ready, step_pulse;
    logic [2:0] debug_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [39:0] fr;

    izh_param_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load_mode   (load_mode),
        .serial_data (serial_data),
        .input_enable(input_enable),
        .param_a     (param_a),
        .param_b     (param_b),
        .param_c     (param_c),
        .param_d     (param_d),
        .params_ready(params_ready),
        .step_pulse  (step_pulse),
        .debug_state (debug_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] make_frame(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c, input logic [7:0] d,
                                               input logic [7:0] trailer);
`ifdef IZH_PARAM_CHECKSUM_EN
        return {a, b, c, d, trailer};
`else
        return {trailer, a, b, c, d};
`endif
    endfunction

    function automatic logic frame_bit(input logic [39:0] f, input int i);
        return (i < FB) ? f[FB-1-i] : 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; load_mode = 1'b0; serial_data = 1'b0; input_enable = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if ({param_a, param_b, param_c, param_d} !== 32'h02_33_BF_08) begin
            n_fail++; $display("FAIL reset_params got=%h want=0233bf08", {param_a, param_b, param_c, param_d});
        end
        n_tests++;
        if (params_ready !== 1'b0 || debug_state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state got ready=%b state=%0d want ready=0 state=0", params_ready, debug_state);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if (step_pulse !== 1'b0 || debug_state !== 3'd0) begin
                n_fail++; $display("FAIL reset_no_run cyc=%0d got pulse=%b state=%0d want 0/0", i, step_pulse, debug_state);
            end
        end
    endtask

    task automatic test_frame_and_run();
        input_enable = 1'b0;
        fr = make_frame(8'h05, 8'h10, 8'hC0, 8'h06, 8'h05 ^ 8'h10 ^ 8'hC0 ^ 8'h06);
        for (int i = 0; i < FB; i++) begin
            load_mode = 1'b1; serial_data = frame_bit(fr, i);
            tick();
            n_tests++;
            if (params_ready !== 1'b0) begin
                n_fail++; $display("FAIL frame_ready_low bit=%0d got=%b want=0", i, params_ready);
            end
        end
        n_tests++;
        if (debug_state !== 3'd2) begin
            n_fail++; $display("FAIL frame_commit_state got=%0d want=2", debug_state);
        end
        load_mode = 1'b0; input_enable = 1'b1;
        tick();
        n_tests++;
        if ({param_a, param_b, param_c, param_d} !== 32'h05_10_C0_06 || params_ready !== 1'b1) begin
            n_fail++; $display("FAIL frame_params got=%h ready=%b want=0510c006 ready=1",
                               {param_a, param_b, param_c, param_d}, params_ready);
        end
        tick();
        n_tests++;
        if (debug_state !== 3'd3 || step_pulse !== 1'b0) begin
            n_fail++; $display("FAIL run_entry got state=%0d pulse=%b want 3/0", debug_state, step_pulse);
        end
        for (int i = 1; i < 12; i++) begin
            tick();
            n_tests++;
            if (step_pulse !== ((i % 4) == 0)) begin
                n_fail++; $display("FAIL run_pulse cyc=%0d got=%b want=%b", i, step_pulse, (i % 4) == 0);
            end
        end
    endtask

    // Entered with the divider at its last phase, so the frame start must swallow the pulse.
    task automatic test_abort();
        fr = make_frame(8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'h00);
        for (int i = 0; i < 10; i++) begin
            load_mode = 1'b1; serial_data = frame_bit(fr, i);
            tick();
            n_tests++;
            if (step_pulse !== 1'b0 || debug_state !== 3'd1 || params_ready !== 1'b0) begin
                n_fail++; $display("FAIL abort_shift bit=%0d got pulse=%b state=%0d ready=%b want 0/1/0",
                                   i, step_pulse, debug_state, params_ready);
            end
        end
        load_mode = 1'b0; input_enable = 1'b0;
        tick();
        n_tests++;
        if (debug_state !== 3'd4 || params_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_state got state=%0d ready=%b want 4/1", debug_state, params_ready);
        end
        tick();
        n_tests++;
        if (debug_state !== 3'd0 || params_ready !== 1'b1 ||
            {param_a, param_b, param_c, param_d} !== 32'h05_10_C0_06) begin
            n_fail++; $display("FAIL abort_after got state=%0d ready=%b params=%h want 0/1/0510c006",
                               debug_state, params_ready, {param_a, param_b, param_c, param_d});
        end
    endtask

    task automatic test_overlong();
        logic [2:0] want_state;
        logic       want_ready;
        fr = make_frame(8'hA1, 8'h7E, 8'h80, 8'hFF, 8'hA1 ^ 8'h7E ^ 8'h80 ^ 8'hFF);
        for (int i = 0; i < 45; i++) begin
            load_mode = 1'b1; serial_data = frame_bit(fr, i);
            tick();
            want_state = (i < FB - 1) ? 3'd1 : (i == FB - 1) ? 3'd2 : 3'd0;
            want_ready = (i >= FB);
            n_tests++;
            if (debug_state !== want_state || params_ready !== want_ready) begin
                n_fail++; $display("FAIL overlong bit=%0d got state=%0d ready=%b want %0d/%b",
                                   i, debug_state, params_ready, want_state, want_ready);
            end
        end
        load_mode = 1'b0;
        tick();
        n_tests++;
        if ({param_a, param_b, param_c, param_d} !== 32'hA1_7E_80_FF || debug_state !== 3'd0) begin
            n_fail++; $display("FAIL overlong_params got=%h state=%0d want=a17e80ff state=0",
                               {param_a, param_b, param_c, param_d}, debug_state);
        end
    endtask

    task automatic test_enable_freeze();
        fr = make_frame(8'h3C, 8'h5A, 8'h81, 8'h0F, 8'h3C ^ 8'h5A ^ 8'h81 ^ 8'h0F);
        for (int i = 0; i < 12; i++) begin
            load_mode = 1'b1; serial_data = frame_bit(fr, i);
            tick();
        end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            serial_data = ~frame_bit(fr, 12);
            tick();
            n_tests++;
            if (debug_state !== 3'd1 || params_ready !== 1'b0) begin
                n_fail++; $display("FAIL freeze_frame cyc=%0d got state=%0d ready=%b want 1/0", i, debug_state, params_ready);
            end
        end
        enable = 1'b1;
        for (int i = 12; i < FB; i++) begin
            serial_data = frame_bit(fr, i);
            tick();
        end
        load_mode = 1'b0; input_enable = 1'b1;
        tick();
        n_tests++;
        if ({param_a, param_b, param_c, param_d} !== 32'h3C_5A_81_0F || params_ready !== 1'b1) begin
            n_fail++; $display("FAIL freeze_params got=%h ready=%b want=3c5a810f ready=1",
                               {param_a, param_b, param_c, param_d}, params_ready);
        end
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if (step_pulse !== (i == 4)) begin
                n_fail++; $display("FAIL freeze_first_pulse cyc=%0d got=%b want=%b", i, step_pulse, i == 4);
            end
        end
        tick();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (step_pulse !== 1'b0 || debug_state !== 3'd3) begin
                n_fail++; $display("FAIL freeze_run cyc=%0d got pulse=%b state=%0d want 0/3", i, step_pulse, debug_state);
            end
        end
        enable = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_tests++;
            if (step_pulse !== (k == 3 || k == 7)) begin
                n_fail++; $display("FAIL freeze_phase cyc=%0d got=%b want=%b", k, step_pulse, k == 3 || k == 7);
            end
        end
        input_enable = 1'b0;
        tick();
    endtask

    task automatic test_reset_midframe();
        fr = make_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
        for (int i = 0; i < 8; i++) begin
            load_mode = 1'b1; serial_data = frame_bit(fr, i);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; load_mode = 1'b0; input_enable = 1'b1;
        tick();
        n_tests++;
        if ({param_a, param_b, param_c, param_d} !== 32'h02_33_BF_08 || params_ready !== 1'b0 ||
            debug_state !== 3'd0) begin
            n_fail++; $display("FAIL midframe_reset got=%h ready=%b state=%0d want=0233bf08/0/0",
                               {param_a, param_b, param_c, param_d}, params_ready, debug_state);
        end
        repeat (3) tick();
        n_tests++;
        if (debug_state !== 3'd0 || step_pulse !== 1'b0) begin
            n_fail++; $display("FAIL midframe_no_run got state=%0d pulse=%b want 0/0", debug_state, step_pulse);
        end
        input_enable = 1'b0;
    endtask

`ifdef IZH_PARAM_CHECKSUM_EN
    task automatic test_checksum();
        fr = make_frame(8'h05, 8'h10, 8'hC0, 8'h06, 8'hD3);
        for (int i = 0; i < FB; i++) begin
            load_mode = 1'b1; serial_data = frame_bit(fr, i);
            tick();
        end
        n_tests++;
        if (debug_state !== 3'd2) begin
            n_fail++; $display("FAIL cksum_good_state got=%0d want=2", debug_state);
        end
        load_mode = 1'b0;
        tick();
        n_tests++;
        if ({param_a, param_b, param_c, param_d} !== 32'h05_10_C0_06 || params_ready !== 1'b1) begin
            n_fail++; $display("FAIL cksum_good_params got=%h ready=%b want=0510c006/1",
                               {param_a, param_b, param_c, param_d}, params_ready);
        end
        fr = make_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
        for (int i = 0; i < FB; i++) begin
            load_mode = 1'b1; serial_data = frame_bit(fr, i);
            tick();
        end
        n_tests++;
        if (debug_state !== 3'd5 || params_ready !== 1'b1) begin
            n_fail++; $display("FAIL cksum_bad_state got state=%0d ready=%b want 5/1", debug_state, params_ready);
        end
        load_mode = 1'b0;
        tick();
        n_tests++;
        if ({param_a, param_b, param_c, param_d} !== 32'h05_10_C0_06 || debug_state !== 3'd0) begin
            n_fail++; $display("FAIL cksum_bad_params got=%h state=%0d want=0510c006/0",
                               {param_a, param_b, param_c, param_d}, debug_state);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_and_run();
        test_abort();
        test_overlong();
        test_enable_freeze();
        test_reset_midframe();
`ifdef IZH_PARAM_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
